// File: rtl/ks42_accumulator.sv
// ---------------------------------------------------------------------------
// ks42_accumulator
//
// Streaming packet accumulator built around the sparse Kogge-Stone adder
// sparse_42bitks (defined below in this file). Operand beats arrive on a
// valid/ready stream; each is registered into stage 1 and added to the
// running total on the following edge. After the last beat of a packet has
// been folded in, the total, a sticky overflow flag and a saturating beat
// count are held on the output valid/ready stream until consumed.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept a beat (function of state only)
//   in_data    in   WIDTH-bit unsigned operand
//   in_last    in   final beat of the packet
//   out_valid  out  result valid (HOLD state)
//   out_ready  in   downstream accepts the result
//   out_sum    out  packet sum modulo 2^WIDTH
//   out_ovf    out  sticky carry-out of the MSB seen in this packet
//   out_count  out  accepted beats, saturating at 2^CNT_W-1
//
// WIDTH must stay 42: the adder is a fixed 42-bit structure.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sparse_42bitks
//
// 42-bit adder, no carry-in, no carry-out. Carries are computed by a
// Kogge-Stone prefix tree only at 4-bit group boundaries ("sparse"); inside
// each group the carry ripples from the group carry-in. Bits 40..41 form a
// short final group that only needs its carry-in from the tree.
//
// Ports:
//   a, b  in   42-bit operands
//   sum   out  (a + b) mod 2^42
// ---------------------------------------------------------------------------
module sparse_42bitks (
    input  logic [41:0] a,
    input  logic [41:0] b,
    output logic [41:0] sum
);

    localparam int NGRP = 10;  // full 4-bit groups covering bits 0..39

    logic [40:0]     gb;       // bit generate; bit 41 generate never used
    logic [41:0]     pb;       // bit propagate
    logic [NGRP-1:0] gg, pg;   // group generate / propagate
    logic [NGRP-1:0] gk, pk;   // prefix tree working values
    logic [NGRP-1:0] ng, np;
    logic [NGRP:0]   cgrp;     // carry into each group (group 10 = bits 40..41)
    logic [41:0]     cy;       // carry into each bit

    always_comb begin
        gb   = a[40:0] & b[40:0];
        pb   = a ^ b;
        gg   = '0;
        pg   = '0;
        ng   = '0;
        np   = '0;
        cgrp = '0;
        cy   = '0;

        // 4-bit group generate/propagate
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = gb[4*j+3]
                  | (pb[4*j+3] & (gb[4*j+2]
                  | (pb[4*j+2] & (gb[4*j+1]
                  | (pb[4*j+1] &  gb[4*j])))));
            pg[j] = &pb[4*j +: 4];
        end

        // Kogge-Stone over the groups: spans 1, 2, 4, 8
        gk = gg;
        pk = pg;
        for (int d = 1; d < NGRP; d = d * 2) begin
            ng = gk;
            np = pk;
            for (int j = d; j < NGRP; j++) begin
                ng[j] = gk[j] | (pk[j] & gk[j-d]);
                np[j] = pk[j] & pk[j-d];
            end
            gk = ng;
            pk = np;
        end

        // No carry-in, so the carry into group j is the prefix generate of
        // groups 0..j-1.
        cgrp[0] = 1'b0;
        for (int j = 1; j <= NGRP; j++)
            cgrp[j] = gk[j-1];

        // Ripple within each group from its boundary carry
        cy[0] = cgrp[0];
        for (int i = 1; i < 42; i++) begin
            if (i % 4 == 0)
                cy[i] = cgrp[i/4];
            else
                cy[i] = gb[i-1] | (pb[i-1] & cy[i-1]);
        end

        sum = pb ^ cy;
    end

endmodule

module ks42_accumulator #(
    parameter int WIDTH = 42,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, next_state;

    // Stage-1 operand register
    logic [WIDTH-1:0] s1_data;
    logic             s1_vld;
    logic             s1_last;

    // Accumulator state
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] add_sum;
    logic             carry;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    sparse_42bitks u_add (
        .a   (acc),
        .b   (s1_data),
        .sum (add_sum)
    );

    // The adder exposes no carry-out; a wrap is visible as the sum dropping
    // below the accumulator it started from.
    assign carry    = (add_sum < acc);
    assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign accept   = in_valid & in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                // State is forced to IDLE during reset, so gating with rst
                // here is enough to hold in_ready low while rst is asserted.
                in_ready = ~rst;
                if (accept)
                    next_state = in_last ? DRAIN : ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (accept && in_last)
                    next_state = DRAIN;
            end
            DRAIN: begin
                // s1 holds the packet's last beat here; it is folded into
                // acc on this edge.
                if (s1_vld && s1_last)
                    next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end else if (state == HOLD) begin
            // Result is stable in HOLD; everything clears on the consume
            // edge so IDLE always starts from a zero total.
            if (out_ready) begin
                s1_data <= '0;
                s1_vld  <= 1'b0;
                s1_last <= 1'b0;
                acc     <= '0;
                ovf     <= 1'b0;
                cnt     <= '0;
            end
        end else begin
            if (s1_vld) begin
                acc <= add_sum;
                ovf <= ovf | carry;
                cnt <= cnt_next;
            end
            // A cycle without an accepted beat is a bubble in stage 1.
            s1_vld <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_last <= in_last;
            end
        end
    end

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_ks42_accumulator.sv
module tb_ks42_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [41:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [41:0] pkt[$];
    logic [41:0] exp_sum;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;

    logic [41:0] mon_sum[$];
    logic        mon_ovf[$];
    logic [7:0]  mon_cnt[$];

    ks42_accumulator #(.WIDTH(42), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Record every consumed result
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_sum.push_back(out_sum);
            mon_ovf.push_back(out_ovf);
            mon_cnt.push_back(out_count);
        end
    end

    // Reference: exact integer total of the packet; wrap and overflow follow
    // from whether that total reaches 2^42.
    task automatic model();
        logic [63:0] t;
        t = 64'd0;
        foreach (pkt[i]) t += 64'(pkt[i]);
        exp_sum = t[41:0];
        exp_ovf = (t >> 42) != 64'd0;
        exp_cnt = (pkt.size() > 255) ? 8'hff : 8'(pkt.size());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat (after gap bubble cycles) and wait for it to be taken.
    task automatic send(input logic [41:0] d, input logic last, input int gap);
        int w;
        w = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stuck at %b, want 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input int gap_max);
        foreach (pkt[i])
            send(pkt[i], (i == pkt.size() - 1), (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!out_valid && w < 400) begin
            tick();
            w++;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid_timeout: out_valid %b, want 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 42'd0 ||
            out_ovf !== 1'b0 || out_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%h ovf=%b cnt=%h, want 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_ovf, out_count);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_wrap();
        pkt = '{42'h3ffffffffff, 42'h00000000001};
        model();
        send_pkt(0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_latency_early: out_valid %b want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_latency: out_valid %b want 1", out_valid);
        end
        vectors++;
        if (out_sum !== exp_sum || out_ovf !== exp_ovf || out_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL wrap_result: sum=%h ovf=%b cnt=%h, want %h %b %h",
                     out_sum, out_ovf, out_count, exp_sum, exp_ovf, exp_cnt);
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        pkt = '{42'h098a635e1};
        model();
        send_pkt(0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL single_in_ready_low: cycle %0d got %b want 0", i, in_ready);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== exp_sum || out_ovf !== exp_ovf || out_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL single_result: vld=%b sum=%h ovf=%b cnt=%h, want 1 %h %b %h",
                     out_valid, out_sum, out_ovf, out_count, exp_sum, exp_ovf, exp_cnt);
        end
        consume();
    endtask

    task automatic test_backpressure();
        pkt = '{42'd1, 42'd2, 42'd3};
        model();
        send(pkt[0], 1'b0, 2);
        send(pkt[1], 1'b0, 1);
        send(pkt[2], 1'b1, 3);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum || out_count !== exp_cnt || out_ovf !== exp_ovf) begin
                miscompares++;
                $display("FAIL bp_hold_stable: cycle %0d vld=%b sum=%h cnt=%h ovf=%b, want 1 %h %h %b",
                         i, out_valid, out_sum, out_count, out_ovf, exp_sum, exp_cnt, exp_ovf);
            end
            tick();
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 42'd0 || out_count !== 8'd0) begin
            miscompares++;
            $display("FAIL bp_to_idle: vld=%b rdy=%b sum=%h cnt=%h, want 0 1 0 0",
                     out_valid, in_ready, out_sum, out_count);
        end
    endtask

    task automatic test_saturation();
        pkt.delete();
        for (int i = 0; i < 300; i++) pkt.push_back(42'd1);
        model();
        send_pkt(0);
        wait_valid();
        vectors++;
        if (out_sum !== exp_sum || out_count !== exp_cnt || out_ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL saturation: sum=%h cnt=%h ovf=%b, want %h %h %b",
                     out_sum, out_count, out_ovf, exp_sum, exp_cnt, exp_ovf);
        end
        consume();
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 3; i++)
            send({10'($urandom_range(0, 1023)), 32'($urandom)}, 1'b0, 0);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 42'd0 || out_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_async: rdy=%b vld=%b sum=%h cnt=%h, want 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count);
        end
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b want 1", in_ready);
        end
        pkt = '{42'd5, 42'd7};
        model();
        send_pkt(0);
        wait_valid();
        vectors++;
        if (out_sum !== exp_sum || out_count !== exp_cnt || out_ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL midreset_result: sum=%h cnt=%h ovf=%b, want %h %h %b",
                     out_sum, out_count, out_ovf, exp_sum, exp_cnt, exp_ovf);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [41:0] es[2];
        logic        eo[2];
        logic [7:0]  ec[2];
        int w;
        mon_sum.delete();
        mon_ovf.delete();
        mon_cnt.delete();
        out_ready = 1'b1;
        pkt = '{42'h045623199, 42'h098a635e1};
        model();
        es[0] = exp_sum; eo[0] = exp_ovf; ec[0] = exp_cnt;
        send_pkt(0);
        pkt = '{42'd1};
        model();
        es[1] = exp_sum; eo[1] = exp_ovf; ec[1] = exp_cnt;
        send_pkt(0);
        w = 0;
        while (mon_sum.size() < 2 && w < 50) begin
            tick();
            w++;
        end
        out_ready = 1'b0;
        vectors++;
        if (mon_sum.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results want 2", mon_sum.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (mon_sum[i] !== es[i] || mon_ovf[i] !== eo[i] || mon_cnt[i] !== ec[i]) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: sum=%h ovf=%b cnt=%h, want %h %b %h",
                             i, mon_sum[i], mon_ovf[i], mon_cnt[i], es[i], eo[i], ec[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_random();
        int len;
        logic big;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 12);
            big = $urandom_range(0, 1) == 1;
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                if (big)
                    pkt.push_back({10'($urandom_range(512, 1023)), 32'($urandom)});
                else
                    pkt.push_back(42'($urandom_range(0, 4095)));
            end
            model();
            send_pkt(2);
            wait_valid();
            repeat ($urandom_range(0, 3)) tick();
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum || out_ovf !== exp_ovf || out_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL random_pkt%0d: vld=%b sum=%h ovf=%b cnt=%h, want 1 %h %b %h",
                         p, out_valid, out_sum, out_ovf, out_count, exp_sum, exp_ovf, exp_cnt);
            end
            consume();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_wrap();
        test_single();
        test_backpressure();
        test_saturation();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ks42_accumulator.md
# ks42_accumulator

Streaming accumulator that sits directly upstream of, and around, the 42-bit sparse Kogge-Stone adder `sparse_42bitks`. It accepts a packet of 42-bit unsigned operands over a valid/ready stream and feeds each one, together with the running total, into one `sparse_42bitks` instance. On the last beat it presents the final sum, a sticky carry-out (overflow) flag and a beat count on an output valid/ready stream. It is the first sequential consumer of the adder and is the block used to exercise it in-system.

## Interface

Parameters:
- `WIDTH`, default 42: operand/sum width. Only 42 is supported because it is fixed by `sparse_42bitks`.
- `CNT_W`, default 8: beat-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  unsigned operand.
- `in_last`  in  1  marks the final beat of a packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  WIDTH  packet sum modulo 2^42.
- `out_ovf`  out  1  sticky: a carry out of bit 41 occurred in the packet.
- `out_count`  out  CNT_W  beats in the packet, saturating at 2^CNT_W-1.

## Operation

- **Registers:**
  - Stage-1 operand register `s1_data`/`s1_vld`/`s1_last`.
  - Accumulator `acc[41:0]`.
  - `ovf`, `cnt`.
  - 2-bit state.
- **Adder:** one `sparse_42bitks` instance with `a = acc`, `b = s1_data`, `sum` driving the accumulator D input. The adder has no carry-out, so carry is detected as `(sum < acc)`, an unsigned compare.
- **States:**
  - IDLE: `acc`=0, `ovf`=0, `cnt`=0, `in_ready`=1.
    - Accepted beat with `in_last`=0 → ACC.
    - Accepted beat with `in_last`=1 → DRAIN.
  - ACC: `in_ready`=1. Each cycle with `s1_vld`=1 does `acc<=sum`, `ovf<=ovf|carry`, `cnt<=sat(cnt+1)`.
    - Accepted beat with `in_last`=1 → DRAIN.
  - DRAIN: `in_ready`=0. The last beat held in s1 is accumulated → HOLD.
  - HOLD: `out_valid`=1, `in_ready`=0; outputs are stable.
    - `out_ready`=1 → IDLE, and `acc`/`ovf`/`cnt`/s1 are cleared on the same edge.
- **Handshake:**
  - A transfer occurs on a rising edge with valid&ready both 1.
  - `in_ready` is a function of state only and never depends on `in_valid`.
  - Beats with `in_valid`=0 in ACC are bubbles: `s1_vld`<=0 and the accumulator holds.
- **Outputs:** `out_sum`=`acc`, `out_ovf`=`ovf`, `out_count`=`cnt`. They are defined only while `out_valid`=1 but are driven from registers at all times.
- **Arithmetic:** sum wraps modulo 2^42. `ovf` sets on any wrap and never clears until the result is consumed or on reset. `cnt` counts accepted beats, including zero-valued ones, and sticks at 255.
- **Reset:** asserting `rst` at any time, including mid-packet or in HOLD, immediately clears all registers and forces state to IDLE. `in_ready`=0 and `out_valid`=0 while `rst`=1; `in_ready`=1 on the first cycle after release.

## Timing

- **Reset values:** `in_ready`=0 during reset and 1 after release; `out_valid`=0; `out_sum`=0; `out_ovf`=0; `out_count`=0.
- **Beat pipeline:** a beat accepted at edge k is in s1 after edge k and in `acc` after edge k+1.
- **Latency:** last beat accepted at edge k → `out_valid`=1 after edge k+1.
- **Throughput:**
  - One beat per cycle within a packet.
  - Minimum packet-to-packet gap is 2 cycles (DRAIN, HOLD), plus any `out_ready` stall.
- **Critical path:** `acc`→`sparse_42bitks`→compare/`acc` D, which must close in a single cycle. No path runs from `out_ready` to `in_ready` within the same cycle.

## Test plan

- **Wrap:** `in_data` 3ffffffffff then 00000000001 (last) → `out_sum`=00000000000, `out_ovf`=1, `out_count`=2, `out_valid` 1 cycle after the last accept.
- **Single beat:** 98a635e1 with `in_last` → `out_sum`=098a635e1, `ovf`=0, `count`=1; `in_ready`=0 until `out_ready`.
- **Backpressure and bubbles:** beats 1, 2, 3 with `in_valid` gaps, `out_ready` held 0 for 5 cycles → sum 6, outputs stable during HOLD, IDLE on the accept edge.
- **Counter saturation:** 300 beats of 1 → `out_sum`=12c, `out_count`=ff, `ovf`=0.
- **Mid-packet reset:** `rst` after 3 beats, then a new packet 5, 7 (last) → `out_sum`=c, `count`=2, `ovf`=0, with no residue from the first packet.
- **Back-to-back packets:** `out_ready` tied to 1, packets {45623199, 98a635e1} and {1} → sums 0de0867 7a and 1, in order, with `ovf` cleared between packets.
